// File: rtl/approx_mul_error_profiler_if.sv
// ----------------------------------------------------------------------------
// approx_mul_error_profiler_if
//
// Bundles the profiler's control/status signals, the operand/product link to
// the approximate multiplier under test and the error statistics.
//
// Modports:
//   master : the profiler; drives operands, status and statistics, receives
//            start/abort and the multiplier product.
//   slave  : the environment (host control plus multiplier under test).
//
// Signals:
//   start_i        begin a sweep (honoured in IDLE only)
//   abort_i        cancel a sweep / clear result_valid_o
//   x_o, y_o       multiplier operands (x is the high half of the sweep index)
//   z_approx_i     product returned by the multiplier
//   busy_o         high while sweeping or draining
//   done_o         one-cycle pulse when the statistics are final
//   result_valid_o statistics are final and held
//   err_cnt_o      number of pairs with a non-zero error distance
//   ed_sum_o       sum of error distances
//   ed_max_o       largest error distance
//   sq_sum_o       sum of squared error distances (zero when not built)
// ----------------------------------------------------------------------------
interface approx_mul_error_profiler_if #(
    parameter int unsigned OP_W = 8
);
    logic                  start_i;
    logic                  abort_i;
    logic [OP_W-1:0]       x_o;
    logic [OP_W-1:0]       y_o;
    logic [2*OP_W-1:0]     z_approx_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  result_valid_o;
    logic [2*OP_W:0]       err_cnt_o;
    logic [4*OP_W-1:0]     ed_sum_o;
    logic [2*OP_W-1:0]     ed_max_o;
    logic [6*OP_W-1:0]     sq_sum_o;

    modport master (
        input  start_i,
        input  abort_i,
        input  z_approx_i,
        output x_o,
        output y_o,
        output busy_o,
        output done_o,
        output result_valid_o,
        output err_cnt_o,
        output ed_sum_o,
        output ed_max_o,
        output sq_sum_o
    );

    modport slave (
        output start_i,
        output abort_i,
        output z_approx_i,
        input  x_o,
        input  y_o,
        input  busy_o,
        input  done_o,
        input  result_valid_o,
        input  err_cnt_o,
        input  ed_sum_o,
        input  ed_max_o,
        input  sq_sum_o
    );
endinterface

// File: rtl/approx_mul_error_profiler.sv
// ----------------------------------------------------------------------------
// approx_mul_error_profiler
//
// Self-running characterisation stage for an OP_W x OP_W unsigned approximate
// multiplier. On start it walks every operand pair {x,y} = k, k = 0 .. 2^(2*OP_W)-1,
// one pair per cycle, compares each returned product with the exact product
// and accumulates the error count, the sum of error distances (ED) and the
// largest ED.
//
// Pipeline (pair k presented in sweep cycle k):
//   delay line : exact product delayed MUL_LAT cycles to line up with z_approx_i
//   stage A    : registers z, exact and valid at the end of cycle k+MUL_LAT
//   stage B    : registers ED = |z - exact| and ED != 0
//   stage C    : accumulates at the end of cycle k+MUL_LAT+2
//
// Optional feature (macro ERR_MSE_EN): a squarer in stage B and a sum-of-ED^2
// accumulator on sq_sum_o. Without the macro sq_sum_o is tied to zero.
//
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset
//   bus  approx_mul_error_profiler_if.master (control, operands, statistics)
// ----------------------------------------------------------------------------
module approx_mul_error_profiler #(
    parameter int unsigned OP_W    = 8,
    parameter int unsigned MUL_LAT = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    approx_mul_error_profiler_if.master         bus
);

    localparam int unsigned PW = 2 * OP_W;
    localparam logic [PW-1:0] KLast = '1;

    typedef enum logic [1:0] {StIdle, StSweep, StDrain, StDone} state_e;

    state_e          state_q;
    logic [PW-1:0]   k_q;
    logic            busy_q;
    logic            done_q;
    logic            result_valid_q;

    logic            clear_acc;
    logic            flush;
    logic            pipe_pending;

    // Start is honoured in IDLE only, and abort always wins over it.
    assign clear_acc = (state_q == StIdle) && bus.start_i && !bus.abort_i;
    assign flush     = ((state_q == StSweep) || (state_q == StDrain)) && bus.abort_i;

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            k_q            <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.abort_i) begin
                        result_valid_q <= 1'b0;
                    end else if (bus.start_i) begin
                        state_q        <= StSweep;
                        k_q            <= '0;
                        busy_q         <= 1'b1;
                        result_valid_q <= 1'b0;
                    end
                end
                StSweep: begin
                    if (bus.abort_i) begin
                        state_q        <= StIdle;
                        k_q            <= '0;
                        busy_q         <= 1'b0;
                        result_valid_q <= 1'b0;
                    end else if (k_q == KLast) begin
                        // Operands park at zero while the pipeline drains.
                        state_q <= StDrain;
                        k_q     <= '0;
                    end else begin
                        k_q <= k_q + PW'(1);
                    end
                end
                StDrain: begin
                    if (bus.abort_i) begin
                        state_q        <= StIdle;
                        busy_q         <= 1'b0;
                        result_valid_q <= 1'b0;
                    end else if (!pipe_pending) begin
                        // Only stage B may still hold a pair; it is accumulated
                        // on this same edge, so the results are final next cycle.
                        state_q        <= StDone;
                        busy_q         <= 1'b0;
                        done_q         <= 1'b1;
                        result_valid_q <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    if (bus.abort_i) begin
                        result_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.x_o            = k_q[PW-1:OP_W];
    assign bus.y_o            = k_q[OP_W-1:0];
    assign bus.busy_o         = busy_q;
    assign bus.done_o         = done_q;
    assign bus.result_valid_o = result_valid_q;

    // ------------------------------------------------------------------------
    // Exact reference product and latency-matching delay line
    // ------------------------------------------------------------------------
    logic          src_valid;
    logic [PW-1:0] src_prod;
    logic          dl_valid;
    logic [PW-1:0] dl_prod;
    logic          dl_pending;

    assign src_valid = (state_q == StSweep);
    assign src_prod  = {{OP_W{1'b0}}, bus.x_o} * {{OP_W{1'b0}}, bus.y_o};

    if (MUL_LAT == 0) begin : g_no_delay
        assign dl_valid   = src_valid;
        assign dl_prod    = src_prod;
        assign dl_pending = 1'b0;
    end else begin : g_delay
        logic [PW-1:0]      prod_q [MUL_LAT];
        logic [MUL_LAT-1:0] valid_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= '0;
                for (int i = 0; i < int'(MUL_LAT); i++) begin
                    prod_q[i] <= '0;
                end
            end else begin
                valid_q[0] <= src_valid && !flush;
                prod_q[0]  <= src_prod;
                for (int i = 1; i < int'(MUL_LAT); i++) begin
                    valid_q[i] <= valid_q[i-1] && !flush;
                    prod_q[i]  <= prod_q[i-1];
                end
            end
        end

        assign dl_valid   = valid_q[MUL_LAT-1];
        assign dl_prod    = prod_q[MUL_LAT-1];
        assign dl_pending = |valid_q;
    end

    // ------------------------------------------------------------------------
    // Stage A: capture product pair
    // ------------------------------------------------------------------------
    logic          a_valid_q;
    logic [PW-1:0] a_z_q;
    logic [PW-1:0] a_exact_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid_q <= 1'b0;
            a_z_q     <= '0;
            a_exact_q <= '0;
        end else begin
            a_valid_q <= dl_valid && !flush;
            a_z_q     <= bus.z_approx_i;
            a_exact_q <= dl_prod;
        end
    end

    assign pipe_pending = dl_pending || a_valid_q;

    // ------------------------------------------------------------------------
    // Stage B: error distance (z may sit above or below the exact product)
    // ------------------------------------------------------------------------
    logic [PW-1:0] ed;
    logic          b_valid_q;
    logic          b_nz_q;
    logic [PW-1:0] b_ed_q;

    assign ed = (a_z_q >= a_exact_q) ? (a_z_q - a_exact_q) : (a_exact_q - a_z_q);

`ifdef ERR_MSE_EN
    logic [2*PW-1:0] ed_sq;
    logic [2*PW-1:0] b_sq_q;

    assign ed_sq = {{PW{1'b0}}, ed} * {{PW{1'b0}}, ed};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_sq_q <= '0;
        end else begin
            b_sq_q <= ed_sq;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_valid_q <= 1'b0;
            b_nz_q    <= 1'b0;
            b_ed_q    <= '0;
        end else begin
            b_valid_q <= a_valid_q && !flush;
            b_nz_q    <= (ed != '0);
            b_ed_q    <= ed;
        end
    end

    // ------------------------------------------------------------------------
    // Stage C: accumulators, wide enough for a full sweep without overflow
    // ------------------------------------------------------------------------
    logic [PW:0]       err_cnt_q;
    logic [4*OP_W-1:0] ed_sum_q;
    logic [PW-1:0]     ed_max_q;
    logic              acc_en;

    // A pair still in stage B when an abort lands is dropped with the rest.
    assign acc_en = b_valid_q && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
            ed_sum_q  <= '0;
            ed_max_q  <= '0;
        end else if (clear_acc) begin
            err_cnt_q <= '0;
            ed_sum_q  <= '0;
            ed_max_q  <= '0;
        end else if (acc_en) begin
            err_cnt_q <= err_cnt_q + {{PW{1'b0}}, b_nz_q};
            ed_sum_q  <= ed_sum_q + {{(4*OP_W-PW){1'b0}}, b_ed_q};
            if (b_ed_q > ed_max_q) begin
                ed_max_q <= b_ed_q;
            end
        end
    end

    assign bus.err_cnt_o = err_cnt_q;
    assign bus.ed_sum_o  = ed_sum_q;
    assign bus.ed_max_o  = ed_max_q;

`ifdef ERR_MSE_EN
    logic [6*OP_W-1:0] sq_sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sq_sum_q <= '0;
        end else if (clear_acc) begin
            sq_sum_q <= '0;
        end else if (acc_en) begin
            sq_sum_q <= sq_sum_q + {{(6*OP_W-2*PW){1'b0}}, b_sq_q};
        end
    end

    assign bus.sq_sum_o = sq_sum_q;
`else
    assign bus.sq_sum_o = '0;
`endif

endmodule

// File: tb/tb_approx_mul_error_profiler.sv
// ----------------------------------------------------------------------------
// tb_approx_mul_error_profiler
//
// Two profilers (MUL_LAT=0 with a combinational multiplier model, MUL_LAT=2
// with a two-stage registered model) run side by side on OP_W=4 so that each
// sweep is 256 pairs. Expected statistics come from a behavioural model and
// are queued when a sweep is started, then popped when done_o appears.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_approx_mul_error_profiler;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned PW     = 2 * OP_W;
    localparam int          NPAIRS = 1 << PW;
    localparam int          BUDGET = NPAIRS + 64;

    typedef struct {
        longint unsigned err;
        longint unsigned sum;
        longint unsigned mx;
        longint unsigned sq;
    } exp_t;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    int   mode  = 0;
    int   cyc   = 0;
    int   base  = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q0[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    approx_mul_error_profiler_if #(.OP_W(OP_W)) if0 ();
    approx_mul_error_profiler_if #(.OP_W(OP_W)) if2 ();

    // Multiplier variants: 0 exact, 1 constant zero, 2 exact+1, 3 exact xor {x,y}
    function automatic logic [PW-1:0] z_model(input int m, input logic [OP_W-1:0] x,
                                              input logic [OP_W-1:0] y);
        logic [PW-1:0] p;
        p = {{OP_W{1'b0}}, x} * {{OP_W{1'b0}}, y};
        case (m)
            1:       return '0;
            2:       return p + 8'd1;
            3:       return p ^ {x, y};
            default: return p;
        endcase
    endfunction

    assign if0.start_i    = start;
    assign if0.abort_i    = abort;
    assign if0.z_approx_i = z_model(mode, if0.x_o, if0.y_o);

    logic [PW-1:0] z2_p = '0;
    logic [PW-1:0] z2_q = '0;
    always @(posedge clk) begin
        z2_p <= z_model(mode, if2.x_o, if2.y_o);
        z2_q <= z2_p;
    end
    assign if2.start_i    = start;
    assign if2.abort_i    = abort;
    assign if2.z_approx_i = z2_q;

    approx_mul_error_profiler #(.OP_W(OP_W), .MUL_LAT(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    approx_mul_error_profiler #(.OP_W(OP_W), .MUL_LAT(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    task automatic check(input string tag, input longint unsigned got,
                         input longint unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int m);
        exp_t e;
        e = '{default: 0};
        for (int k = 0; k < NPAIRS; k++) begin
            logic [OP_W-1:0] x;
            logic [OP_W-1:0] y;
            longint unsigned p;
            longint unsigned z;
            longint unsigned ed;
            x  = k[PW-1:OP_W];
            y  = k[OP_W-1:0];
            p  = longint'(x) * longint'(y);
            z  = longint'(z_model(m, x, y));
            ed = (z > p) ? (z - p) : (p - z);
            if (ed != 0) e.err++;
            e.sum += ed;
            if (ed > e.mx) e.mx = ed;
`ifdef ERR_MSE_EN
            e.sq += ed * ed;
`endif
        end
        return e;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, " dut0 ctl"}, {if0.busy_o, if0.done_o, if0.result_valid_o}, 0);
        check({tag, " dut0 xy"},  {if0.x_o, if0.y_o}, 0);
        check({tag, " dut0 acc"}, {if0.err_cnt_o, if0.ed_sum_o, if0.ed_max_o}, 0);
        check({tag, " dut0 sq"},  if0.sq_sum_o, 0);
        check({tag, " dut2 ctl"}, {if2.busy_o, if2.done_o, if2.result_valid_o}, 0);
        check({tag, " dut2 xy"},  {if2.x_o, if2.y_o}, 0);
        check({tag, " dut2 acc"}, {if2.err_cnt_o, if2.ed_sum_o, if2.ed_max_o}, 0);
        check({tag, " dut2 sq"},  if2.sq_sum_o, 0);
    endtask

    // Ends at the falling edge of sweep cycle 0.
    task automatic kick(input int m, input bit push);
        exp_t e;
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        if (push) begin
            e = model(m);
            q0.push_back(e);
            q2.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        base  = cyc;
    endtask

    task automatic score(input string tag, input exp_t e, input int c, input int exp_c,
                         input int busy, input longint unsigned err,
                         input longint unsigned sum, input longint unsigned mx,
                         input longint unsigned sq, input logic rv);
        check({tag, " done cycle"}, c, exp_c);
        check({tag, " busy cycles"}, busy, exp_c);
        check({tag, " result_valid"}, rv, 1);
        check({tag, " err_cnt"}, err, e.err);
        check({tag, " ed_sum"}, sum, e.sum);
        check({tag, " ed_max"}, mx, e.mx);
        check({tag, " sq_sum"}, sq, e.sq);
    endtask

    task automatic wait_done(input string tag);
        bit seen0 = 0;
        bit seen2 = 0;
        int busy0;
        int busy2;
        int c;
        c     = cyc - base;
        busy0 = c;
        busy2 = c;
        for (int i = 0; i < BUDGET && !(seen0 && seen2); i++) begin
            if (i > 0) @(negedge clk);
            c = cyc - base;
            if (if0.busy_o) busy0++;
            if (if2.busy_o) busy2++;
            if (!seen0 && if0.done_o) begin
                seen0 = 1;
                if (q0.size() == 0) check({tag, " dut0 unexpected done"}, 1, 0);
                else score({tag, " dut0"}, q0.pop_front(), c, NPAIRS + 2, busy0,
                           if0.err_cnt_o, if0.ed_sum_o, if0.ed_max_o, if0.sq_sum_o,
                           if0.result_valid_o);
            end
            if (!seen2 && if2.done_o) begin
                seen2 = 1;
                if (q2.size() == 0) check({tag, " dut2 unexpected done"}, 1, 0);
                else score({tag, " dut2"}, q2.pop_front(), c, NPAIRS + 4, busy2,
                           if2.err_cnt_o, if2.ed_sum_o, if2.ed_max_o, if2.sq_sum_o,
                           if2.result_valid_o);
            end
        end
        if (!seen0) check({tag, " dut0 done timeout"}, 0, 1);
        if (!seen2) check({tag, " dut2 done timeout"}, 0, 1);
        @(negedge clk);
        check({tag, " done pulse width"}, {if0.done_o, if2.done_o}, 0);
        check({tag, " result held"}, {if0.result_valid_o, if2.result_valid_o}, 2'b11);
    endtask

    initial begin
        bit spurious;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Sweeps over each multiplier variant
        for (int m = 0; m < 4; m++) begin
            kick(m, 1);
            wait_done($sformatf("sweep m%0d", m));
        end

        // Abort at sweep cycle 100, then a clean sweep
        kick(1, 0);
        repeat (100) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort busy", {if0.busy_o, if2.busy_o}, 0);
        check("abort result_valid", {if0.result_valid_o, if2.result_valid_o}, 0);
        check("abort xy", {if0.x_o, if0.y_o, if2.x_o, if2.y_o}, 0);
        spurious = 0;
        repeat (NPAIRS + 8) begin
            @(negedge clk);
            if (if0.done_o || if2.done_o || if0.busy_o || if2.busy_o) spurious = 1;
        end
        check("abort stays idle", spurious, 0);
        kick(2, 1);
        wait_done("after abort");

        // Start pulsed mid-sweep must not restart it
        kick(3, 1);
        repeat (50) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mid start xy dut0", {if0.x_o, if0.y_o}, 51);
        check("mid start xy dut2", {if2.x_o, if2.y_o}, 51);
        wait_done("mid start");

        // Start and abort together in IDLE: abort wins and clears result_valid
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("idle abort busy", {if0.busy_o, if2.busy_o}, 0);
        check("idle abort result_valid", {if0.result_valid_o, if2.result_valid_o}, 0);

        // Asynchronous reset while both profilers are draining
        kick(1, 0);
        repeat (257) @(negedge clk);
        check("drain busy", {if0.busy_o, if2.busy_o}, 2'b11);
        #2 rst = 1'b1;
        #1 check_zero("reset in drain");
        @(negedge clk);
        rst = 1'b0;
        kick(1, 1);
        wait_done("after reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
